serializer_tx6: RTL
===================

// Module: serializer_tx6
// PURPOSE
// - Parallel-in/serial-out transmitter; feeds the serial_input of the right-shift receiver register (shiftregister_right6).
// - Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB first, one bit per clockpulse.
// - The receiver fills from its MSB and shifts right, so after WIDTH edges it holds the word unchanged.
// - Sits between the stimulus/control logic and the serial link of the experiment-7 datapath.
// PARAMETERS
// - WIDTH       6   data bits per frame (>=2)
// - IDLE_LEVEL  0   serial_output level outside a frame; also the fill bit shifted into the MSB
// PORTS
// - clockpulse     in   1              system clock, rising edge
// - clear          in   1              asynchronous, active-low reset
// - load_valid     in   1              load_data is valid
// - load_ready     out  1              transmitter can accept a word
// - load_data      in   WIDTH          word to transmit
// - abort          in   1              synchronous frame cancel
// - serial_output  out  1              serial bit stream, LSB first
// - frame_active   out  1              serial_output carries a frame bit
// - bit_count      out  clog2(WIDTH+2) index of the bit currently on serial_output
// - done           out  1              one-cycle pulse after a completed frame
// BEHAVIOUR
// - Reset (clear=0, async): state=IDLE, shift register=0, bit_count=0.
//   Outputs: load_ready=0 while held, then 1; serial_output=IDLE_LEVEL; frame_active=0; done=0.
// - Reset mid-frame: the frame is dropped at once. No done pulse.
// - FSM states:
//   - IDLE   load_ready=1, frame_active=0, serial_output=IDLE_LEVEL.
//   - SHIFT  load_ready=0, frame_active=1, serial_output=shreg[0].
//   - PARITY only with the macro; see CONFIGURATION.
// - Accept: load_valid & load_ready & ~abort at edge k.
//   - shreg<=load_data, bit_count<=0, state<=SHIFT.
//   - Cycles k+1..k+WIDTH carry bits 0..WIDTH-1 on serial_output.
// - SHIFT, each edge: shreg<={IDLE_LEVEL, shreg[WIDTH-1:1]}, bit_count++.
//   - On the edge where bit_count==WIDTH-1: next state is IDLE, or PARITY with the macro.
// - done is registered. It is high for exactly the first cycle back in IDLE (cycle k+WIDTH+1).
//   load_ready is also high in that cycle.
//   - Back-to-back frames: the next accept is no earlier than edge k+WIDTH+1, giving a 1-cycle IDLE gap.
// - abort=1 at any edge: state<=IDLE, bit_count<=0, no done pulse, serial_output returns to IDLE_LEVEL.
//   - abort together with load_valid in IDLE: abort wins and the word is not accepted.
// - load_valid while busy: ignored. The source holds the word until load_ready.
// - load_data is sampled only at the accept edge. Later changes do not affect the frame.
// - All outputs come from registered state only. There is no combinational path from an input to an output.
// - bit_count is held at 0 in IDLE.
// CONFIGURATION
// - SERIALIZER_PARITY_EN defined:
//   - After bit WIDTH-1, the PARITY state drives one extra cycle (k+WIDTH+1).
//   - That cycle carries even parity (^data) with frame_active=1 and bit_count=WIDTH.
//   - done then pulses at k+WIDTH+2.
//   - abort in PARITY behaves as in SHIFT.
// - Not defined: there is no PARITY state and no parity logic. The frame is exactly WIDTH bits.
// TESTING
// - Reset, then release with load_valid=0.
//   -> serial_output=0, frame_active=0, load_ready=1, done=0 for 10 cycles.
// - Load 6'b101101 at edge k.
//   -> cycles k+1..k+6 carry serial 1,0,1,1,0,1 and bit_count 0..5.
//   -> done=1 only in k+7, where load_ready=1.
// - Loopback into shiftregister_right6 on the same clock, load 6'b110010.
//   -> the receiver's signal_q==6'b110010 at cycle k+7.
// - Assert abort at cycle k+3 of a 6'b111111 frame.
//   -> serial_output=0 and load_ready=1 from k+4; no done pulse.
// - Pull clear low mid-frame (bit 2), then release.
//   -> all outputs reach reset values immediately; the next load sends a full frame from bit 0.
// - With SERIALIZER_PARITY_EN:
//   -> 6'b101101 sends parity bit 0 at k+7.
//   -> 6'b000111 sends parity bit 1 at k+7.
//   -> in both cases done=1 at k+8.

Source files
------------

// File: rtl/serializer_tx6.sv
// serializer_tx6: parallel-in/serial-out transmitter, LSB first, valid/ready load.
// Optional feature macro: SERIALIZER_PARITY_EN appends one even-parity bit per frame.
module serializer_tx6 #(
   parameter int   WIDTH      = 6,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic                          clockpulse,
   input  logic                          clear,
   input  logic                          load_valid,
   output logic                          load_ready,
   input  logic [WIDTH-1:0]              load_data,
   input  logic                          abort,
   output logic                          serial_output,
   output logic                          frame_active,
   output logic [$clog2(WIDTH+2)-1:0]    bit_count,
   output logic                          done
);

   localparam int CW = $clog2(WIDTH+2);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH-1);

`ifdef SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [CW-1:0]    count_q, count_n;
   logic             done_q, done_n;
   logic             armed;
`ifdef SERIALIZER_PARITY_EN
   logic             parity_q, parity_n;
`endif

   // Register all state; armed keeps load_ready low until the first edge after reset release
   always_ff @(posedge clockpulse or negedge clear) begin
      if (!clear) begin
         state   <= IDLE;
         shreg   <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
         armed   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         count_q <= count_n;
         done_q  <= done_n;
         armed   <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
         parity_q <= parity_n;
`endif
      end
   end

   // Next-state and output decode; outputs depend only on registered state
   always_comb begin
      state_n       = state;
      shreg_n       = shreg;
      count_n       = count_q;
      done_n        = 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_n      = parity_q;
`endif
      load_ready    = armed && (state == IDLE);
      frame_active  = (state != IDLE);
      serial_output = IDLE_LEVEL;
      bit_count     = count_q;
      done          = done_q;

      case (state)
         IDLE: begin
            if (load_valid && armed && !abort) begin
               shreg_n = load_data;
               count_n = '0;
               state_n = SHIFT;
`ifdef SERIALIZER_PARITY_EN
               parity_n = ^load_data;
`endif
            end
         end
         SHIFT: begin
            serial_output = shreg[0];
            shreg_n       = {IDLE_LEVEL, shreg[WIDTH-1:1]};
            if (count_q == LAST_BIT) begin
`ifdef SERIALIZER_PARITY_EN
               state_n = PARITY;
               count_n = CW'(WIDTH);
`else
               state_n = IDLE;
               count_n = '0;
               done_n  = 1'b1;
`endif
            end else begin
               count_n = count_q + CW'(1);
            end
         end
`ifdef SERIALIZER_PARITY_EN
         PARITY: begin
            serial_output = parity_q;
            state_n       = IDLE;
            count_n       = '0;
            done_n        = 1'b1;
         end
`endif
         default: begin
            state_n = IDLE;
            count_n = '0;
         end
      endcase

      if (abort) begin
         state_n = IDLE;
         count_n = '0;
         done_n  = 1'b0;
      end
   end

endmodule
